// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle control FSM for an RV32 subset; MC_PERF_CNT_EN enables the instret counter
module mc_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_write,
  output logic        alu_src,
  output logic [2:0]  alu_ctrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        wb_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_e;

  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ} cls_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_e     state_q;
  cls_e       cls_q;
  logic [2:0] op_q;
  logic       illegal_q;
  // Low through reset and until the first edge after release, so fetch
  // requests start only on that edge.
  logic       run_q;

  logic       f3_ok;
  logic [2:0] f3_op;
  logic       dec_legal;
  cls_e       dec_cls;
  logic [2:0] dec_op;

  // Map funct3 to the ALU op shared by the R and I formats.
  always_comb begin
    f3_ok = 1'b1;
    f3_op = ALU_ADD;
    case (funct3)
      3'b000:  f3_op = ALU_ADD;
      3'b111:  f3_op = ALU_AND;
      3'b110:  f3_op = ALU_OR;
      3'b100:  f3_op = ALU_XOR;
      3'b010:  f3_op = ALU_SLT;
      default: f3_ok = 1'b0;
    endcase
  end

  // Classify the instruction register contents; anything unmatched is illegal.
  always_comb begin
    dec_legal = 1'b0;
    dec_cls   = C_R;
    dec_op    = ALU_ADD;
    case (opcode)
      OP_R: begin
        dec_cls = C_R;
        if (funct7 == 7'b0000000 && f3_ok) begin
          dec_legal = 1'b1;
          dec_op    = f3_op;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end
      end
      OP_I: begin
        dec_cls   = C_I;
        dec_legal = f3_ok;
        dec_op    = f3_op;
      end
      OP_LW: begin
        dec_cls   = C_LW;
        dec_legal = (funct3 == 3'b010);
      end
      OP_SW: begin
        dec_cls   = C_SW;
        dec_legal = (funct3 == 3'b010);
      end
      OP_BEQ: begin
        dec_cls   = C_BEQ;
        dec_legal = (funct3 == 3'b000);
        dec_op    = ALU_SUB;
      end
      default: ;
    endcase
  end

  // Main sequencer: state, registered class and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      op_q      <= ALU_ADD;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_FETCH: if (run_q && imem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q <= dec_cls;
          op_q  <= dec_op;
          if (dec_legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_R, C_I:   state_q <= S_WB;
            C_LW, C_SW: state_q <= S_MEM;
            default:    state_q <= S_FETCH;
          endcase
        end
        S_MEM: if (dmem_ready) state_q <= (cls_q == C_LW) ? S_WB : S_FETCH;
        S_WB:   state_q <= S_FETCH;
        S_TRAP: state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Decode outputs from registered state/class; only the fetch and branch
  // strobes look at live inputs.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_write = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    wb_sel    = 1'b0;
    alu_ctrl  = op_q;
    alu_src   = (cls_q == C_I) || (cls_q == C_LW) || (cls_q == C_SW);
    case (state_q)
      S_FETCH: begin
        imem_req = run_q;
        ir_we    = run_q & imem_ready;
        pc_we    = run_q & imem_ready;
      end
      S_EXEC: begin
        if (cls_q == C_BEQ) begin
          pc_sel = 1'b1;
          pc_we  = alu_zero;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (cls_q == C_LW);
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

`ifdef MC_PERF_CNT_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = (state_q == S_WB)
               || (state_q == S_EXEC && cls_q == C_BEQ)
               || (state_q == S_MEM && cls_q == C_SW && dmem_ready);

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 32'd0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized scoreboard bench for mc_controller
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic        alu_zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_we, pc_we, pc_sel, reg_write, alu_src;
  logic [2:0]  alu_ctrl;
  logic        dmem_req, dmem_we, wb_sel, illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_write(reg_write), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .wb_sel(wb_sel), .illegal(illegal),
    .state(state), .instret(instret)
  );

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;

  typedef struct {
    logic        legal;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    int          dm_cycles;
    logic        dm_we;
    int          rw;
    logic        wb_sel;
    int          br;
    int          cycles;
    logic [11:0] seq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef MC_PERF_CNT_EN
    return model_retired;
`else
    return 32'd0;
`endif
  endfunction

  // Instruction-level reference: legality, ALU setup, memory/writeback/branch
  // effects and latency, straight from the ISA subset table.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic az, input int wd);
    exp_t e;
    logic ok;
    logic [2:0] a;
    ok = 1'b1;
    a  = 3'd0;
    case (f3)
      3'b000: a = 3'd0;
      3'b111: a = 3'd2;
      3'b110: a = 3'd3;
      3'b100: a = 3'd4;
      3'b010: a = 3'd5;
      default: ok = 1'b0;
    endcase
    e.legal = 1'b0; e.alu_ctrl = 3'd0; e.alu_src = 1'b0; e.dm_cycles = 0;
    e.dm_we = 1'b0; e.rw = 0; e.wb_sel = 1'b0; e.br = 0;
    e.cycles = 3; e.seq = {3'd0, 3'd0, 3'd1, 3'd5};
    case (op)
      OP_R: begin
        if (f7 == 7'b0000000 && ok) begin e.legal = 1'b1; e.alu_ctrl = a; end
        else if (f7 == 7'b0100000 && f3 == 3'b000) begin e.legal = 1'b1; e.alu_ctrl = 3'd1; end
        if (e.legal) begin e.rw = 1; e.cycles = 4; e.seq = {3'd0, 3'd1, 3'd2, 3'd4}; end
      end
      OP_I: if (ok) begin
        e.legal = 1'b1; e.alu_ctrl = a; e.alu_src = 1'b1;
        e.rw = 1; e.cycles = 4; e.seq = {3'd0, 3'd1, 3'd2, 3'd4};
      end
      OP_LW: if (f3 == 3'b010) begin
        e.legal = 1'b1; e.alu_src = 1'b1; e.dm_cycles = wd + 1;
        e.rw = 1; e.wb_sel = 1'b1; e.cycles = 5 + wd; e.seq = {3'd0, 3'd1, 3'd2, 3'd3};
      end
      OP_SW: if (f3 == 3'b010) begin
        e.legal = 1'b1; e.alu_src = 1'b1; e.dm_cycles = wd + 1; e.dm_we = 1'b1;
        e.cycles = 4 + wd; e.seq = {3'd0, 3'd1, 3'd2, 3'd3};
      end
      OP_BEQ: if (f3 == 3'b000) begin
        e.legal = 1'b1; e.alu_ctrl = 3'd1; e.br = az ? 1 : 0;
        e.cycles = 3; e.seq = {3'd0, 3'd1, 3'd2, 3'd0};
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor state
  logic        in_instr = 1'b0;
  int          cyc, nseq, br, bad, rw, dm;
  logic [11:0] seq;
  logic [2:0]  ex_alu;
  logic        ex_src, wbs, dwe;

  task automatic finish_instr(input logic obs_legal);
    exp_t e;
    in_instr = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: actual=instruction_seen expected=none_pending");
    end else begin
      e = exp_q.pop_front();
      chk("legal", obs_legal, e.legal);
      chk("cycles", cyc, e.cycles);
      chk("state_seq", seq, e.seq);
      if (e.legal) begin
        chk("alu_ctrl", ex_alu, e.alu_ctrl);
        chk("alu_src", ex_src, e.alu_src);
        chk("dmem_cycles", dm, e.dm_cycles);
        chk("dmem_we", dwe, e.dm_we);
        chk("reg_write_cnt", rw, e.rw);
        if (e.rw != 0) chk("wb_sel", wbs, e.wb_sel);
        chk("branch_pc_we", br, e.br);
        chk("stray_strobe", bad, 0);
        model_retired++;
        chk("instret", instret, exp_instret());
      end else begin
        chk("illegal_flag", illegal, 1);
        chk("trap_path_strobes", rw + dm + br + bad, 0);
      end
    end
  endtask

  // Observe the DUT each negedge and retire scoreboard entries as instructions complete.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_instr = 1'b0;
    end else begin
      if (in_instr) begin
        if (nseq < 4) begin seq = {seq[8:0], state}; nseq++; end
        if (state == 3'd0) begin
          finish_instr(1'b1);
        end else begin
          cyc++;
          if (state == 3'd2) begin ex_alu = alu_ctrl; ex_src = alu_src; end
          if (pc_we) begin if (pc_sel) br++; else bad++; end
          if (reg_write) begin rw++; wbs = wb_sel; end
          if (dmem_req) begin dm++; dwe = dwe | dmem_we; end
          if (dmem_we && !dmem_req) bad++;
          if (ir_we || imem_req) bad++;
          if (state == 3'd5) finish_instr(1'b0);
        end
      end else if (state == 3'd5) begin
        chk("trap_hold_illegal", illegal, 1);
        chk("trap_hold_strobes", {imem_req, ir_we, pc_we, reg_write, dmem_req, dmem_we}, 0);
      end
      if (!in_instr && state == 3'd0) begin
        if (ir_we) begin
          chk("fetch_pc_we", {pc_we, pc_sel}, 2'b10);
          in_instr = 1'b1;
          cyc = 1; nseq = 1; seq = 12'd0;
          br = 0; bad = 0; rw = 0; dm = 0;
          ex_alu = 3'd7; ex_src = 1'b0; wbs = 1'b0; dwe = 1'b0;
        end else if (!imem_ready) begin
          chk("fetch_wait_strobes", {ir_we, pc_we}, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_instret", instret, 0);
    chk("rst_strobes", {imem_req, ir_we, pc_we, reg_write, dmem_req, dmem_we, wb_sel}, 0);
    chk("rst_alu", {alu_ctrl, alu_src}, 0);
    exp_q.delete();
    model_retired = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_release_req", imem_req, 0);
    tick();
    chk("first_edge_req", imem_req, 1);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic az, input int wi, input int wd, output logic trapped);
    int  mcnt;
    logic done;
    exp_q.push_back(model(op, f3, f7, az, wd));
    opcode = op; funct3 = f3; funct7 = f7; alu_zero = az;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    trapped = 1'b0;
    repeat (wi) tick();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    mcnt = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (state == 3'd0) done = 1'b1;
      else if (state == 3'd5) begin trapped = 1'b1; done = 1'b1; end
      else begin
        if (dmem_req) begin dmem_ready = (mcnt == wd); mcnt++; end
        else dmem_ready = 1'b0;
        tick();
      end
    end
    dmem_ready = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: actual=state_%0d expected=return_to_fetch", state);
    end
  endtask

  task automatic trap_and_reset();
    repeat (10) tick();
    chk("trap_state_after_10", state, 3'd5);
    chk("trap_illegal_after_10", illegal, 1);
    do_reset();
  endtask

  initial begin
    logic       tr;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         k;

    do_reset();

    issue(OP_R, 3'b000, 7'b0000000, 1'b0, 0, 0, tr);      // ADD, ready high
    issue(OP_LW, 3'b010, 7'd0, 1'b0, 0, 3, tr);           // LW, 3 dmem wait cycles
    issue(OP_BEQ, 3'b000, 7'd0, 1'b1, 0, 0, tr);          // taken
    issue(OP_BEQ, 3'b000, 7'd0, 1'b0, 0, 0, tr);          // not taken
    issue(OP_R, 3'b000, 7'b0100000, 1'b0, 1, 0, tr);      // SUB

    issue(7'b1111111, 3'b000, 7'd0, 1'b0, 0, 0, tr);
    chk("trap_taken", tr, 1);
    trap_and_reset();

    // SW abandoned by reset during its dmem wait
    exp_q.push_back(model(OP_SW, 3'b010, 7'd0, 1'b0, 50));
    opcode = OP_SW; funct3 = 3'b010; funct7 = 7'd0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int c = 0; c < 10 && !dmem_req; c++) tick();
    repeat (3) tick();
    chk("sw_wait_dmem_req", {dmem_req, dmem_we}, 2'b11);
    do_reset();
    chk("sw_abort_no_retire", instret, 0);

    // Three ADDI and one SW from a clean counter
    for (int i = 0; i < 3; i++) issue(OP_I, 3'b000, 7'($urandom), 1'b0, 0, 0, tr);
    issue(OP_SW, 3'b010, 7'd0, 1'b0, 0, 0, tr);
`ifdef MC_PERF_CNT_EN
    chk("perf_instret_4", instret, 32'd4);
`else
    chk("perf_instret_tied", instret, 32'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 6);
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) :
           (($urandom_range(0, 1) == 1) ? 7'b0000000 : 7'b0100000);
      case (k)
        0, 6: op = OP_R;
        1: op = OP_I;
        2: begin op = OP_LW; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
        3: begin op = OP_SW; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
        4: begin op = OP_BEQ; if ($urandom_range(0, 3) != 0) f3 = 3'b000; end
        default: op = 7'($urandom);
      endcase
      issue(op, f3, f7, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), tr);
      if (tr) trap_and_reset();
    end

    repeat (2) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
